serial_logic_processor: RTL

//  Parametrised bit-serial logic processor: two WIDTH-bit registers A and B combined by a 3-bit

---
 rtl/serial_logic_processor_pkg.sv | 29 ++
 rtl/serial_logic_processor_if.sv | 26 ++
 rtl/serial_logic_processor_bit_alu.sv | 45 ++++
 rtl/serial_logic_processor.sv | 121 ++++++++++++
 4 files changed

// File: rtl/serial_logic_processor_pkg.sv
// Shared types for the bit-serial logic processor.
// Function, route and FSM state encodings.
package slp_pkg;

  typedef enum logic [2:0] {
    F_AND   = 3'b000,
    F_OR    = 3'b001,
    F_XOR   = 3'b010,
    F_ONES  = 3'b011,
    F_NAND  = 3'b100,
    F_NOR   = 3'b101,
    F_XNOR  = 3'b110,
    F_ZEROS = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    R_KEEP = 2'b00,
    R_TO_B = 2'b01,
    R_TO_A = 2'b10,
    R_SWAP = 2'b11
  } route_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } state_e;

endpackage

// File: rtl/serial_logic_processor_if.sv
// Load/execute bus and register/status readback.
// master drives commands, slave is the processor.
interface slp_if #(
  parameter int WIDTH = 8
);
  logic             LoadA;
  logic             LoadB;
  logic             Execute;
  logic [WIDTH-1:0] Din;
  logic [2:0]       F;
  logic [1:0]       R;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             Busy;
  logic             Done;

  modport master (
    output LoadA, LoadB, Execute, Din, F, R,
    input  Aval, Bval, Busy, Done
  );

  modport slave (
    input  LoadA, LoadB, Execute, Din, F, R,
    output Aval, Bval, Busy, Done
  );
endinterface

// File: rtl/serial_logic_processor_bit_alu.sv
// One-bit logic function plus result routing.
// Purely combinational; shared by serial and parallel builds.
module slp_bit_alu
  import slp_pkg::*;
(
  input  logic   a,
  input  logic   b,
  input  func_e  func,
  input  route_e route,
  output logic   f,
  output logic   a_n,
  output logic   b_n
);

  always_comb begin
    f = 1'b0;
    unique case (func)
      F_AND:   f = a & b;
      F_OR:    f = a | b;
      F_XOR:   f = a ^ b;
      F_ONES:  f = 1'b1;
      F_NAND:  f = ~(a & b);
      F_NOR:   f = ~(a | b);
      F_XNOR:  f = ~(a ^ b);
      F_ZEROS: f = 1'b0;
      default: f = 1'b0;
    endcase
  end

  always_comb begin
    a_n = a;
    b_n = b;
    unique case (route)
      R_KEEP: ;
      R_TO_B: b_n = f;
      R_TO_A: a_n = f;
      R_SWAP: begin
        a_n = b;
        b_n = a;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/serial_logic_processor.sv
// Bit-serial A/B logic processor with Busy/Done handshake.
// Define SERIAL_LOGIC_PROC_PARALLEL_EN for single-cycle operation.
module serial_logic_processor
  import slp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic Clk,
  input  logic Reset,
  slp_if.slave bus
);

  state_e           state;
  state_e           state_nx;
  func_e            op_f;
  route_e           op_r;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] a_new;
  logic [WIDTH-1:0] b_new;
  logic             last;

`ifdef SERIAL_LOGIC_PROC_PARALLEL_EN
  logic [WIDTH-1:0] unused_f;

  for (genvar i = 0; i < WIDTH; i++) begin : g_alu
    slp_bit_alu u_alu (
      .a     (a_q[i]),
      .b     (b_q[i]),
      .func  (op_f),
      .route (op_r),
      .f     (unused_f[i]),
      .a_n   (a_new[i]),
      .b_n   (b_new[i])
    );
  end

  assign last = 1'b1;
`else
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt;
  logic          a_bit;
  logic          b_bit;
  logic          unused_f;

  slp_bit_alu u_alu (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .func  (op_f),
    .route (op_r),
    .f     (unused_f),
    .a_n   (a_bit),
    .b_n   (b_bit)
  );

  assign a_new = {a_bit, a_q[WIDTH-1:1]};
  assign b_new = {b_bit, b_q[WIDTH-1:1]};
  assign last  = (cnt == CW'(WIDTH - 1));

  // Cleared outside SHIFT so every op starts from bit 0.
  always_ff @(posedge Clk) begin
    if (Reset || state != SHIFT || last)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.Execute) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = HOLD;
      HOLD:    if (!bus.Execute) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.Busy = (state == SHIFT);
    bus.Done = (state == HOLD);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_f <= F_AND;
      op_r <= R_KEEP;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Execute) begin
            op_f <= func_e'(bus.F);
            op_r <= route_e'(bus.R);
          end else begin
            if (bus.LoadA) a_q <= bus.Din;
            if (bus.LoadB) b_q <= bus.Din;
          end
        end
        SHIFT: begin
          a_q <= a_new;
          b_q <= b_new;
        end
        default: ;
      endcase
    end
  end

  assign bus.Aval = a_q;
  assign bus.Bval = b_q;

endmodule
